// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic [3:0]  BE_ALL    = 4'b1111;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and bus-side signals of the memory arbiter, grouped by role.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic              inst_cancel;
  logic [ADDR_W-1:0] pc_F;
  logic [DATA_W-1:0] inst_F;
  logic              inst_mem_ack;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] alu_out_M;
  logic [DATA_W-1:0] write_data_M;
  logic [3:0]        byte_en_M;
  logic [DATA_W-1:0] read_data_M;
  logic              data_mem_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Arbiter view: serves the pipeline requesters and drives the memory bus.
  modport slave (
    input  inst_req, inst_cancel, pc_F,
    output inst_F, inst_mem_ack,
    input  data_req, data_we, alu_out_M, write_data_M, byte_en_M,
    output read_data_M, data_mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  // Environment view: pipeline plus external memory.
  modport master (
    output inst_req, inst_cancel, pc_F,
    input  inst_F, inst_mem_ack,
    output data_req, data_we, alu_out_M, write_data_M, byte_en_M,
    input  read_data_M, data_mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant chooser: data wins unless instruction fetch is starved.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_inst,
  output logic             grant_data
);

  logic starved;

  // Grant decision from the current request levels and starvation count.
  always_comb begin
    starved    = (starve_cnt == CNT_W'(STARVE_MAX));
    grant_inst = inst_req & (~data_req | starved);
    grant_data = data_req & ~grant_inst;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and M-stage data,
// one req/ack transaction at a time, with registered one-cycle completion acks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(WORD_MASK);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] inst_f_q, inst_f_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              inst_ack_q, inst_ack_d;
  logic              data_ack_q, data_ack_d;
  logic              grant_inst, grant_data;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .starve_cnt (starve_cnt_q),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  // Next-state, bus field and response computation.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    inst_f_d     = inst_f_q;
    read_data_d  = read_data_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_inst) begin
          state_d      = INST;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = BE_ALL;
          mem_addr_d   = bus.pc_F & ADDR_MASK;
          starve_cnt_d = {CNT_W{1'b0}};
        end else if (grant_data) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.data_we;
          mem_be_d    = bus.byte_en_M;
          mem_addr_d  = bus.alu_out_M & ADDR_MASK;
          mem_wdata_d = bus.write_data_M;
          if (bus.inst_req && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      INST: begin
        // A flush on the ack cycle itself must also suppress the result.
        if (bus.inst_cancel) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!(drop_q || bus.inst_cancel)) begin
            inst_f_d   = bus.mem_rdata;
            inst_ack_d = 1'b1;
          end else begin
            inst_ack_d = 1'b0;
          end
        end else begin
          state_d = INST;
        end
      end
      DATA: begin
        if (bus.mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          data_ack_d = 1'b1;
          if (!mem_we_q) begin
            read_data_d = bus.mem_rdata;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= {CNT_W{1'b0}};
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_be_q     <= 4'b0000;
      inst_f_q     <= {DATA_W{1'b0}};
      read_data_q  <= {DATA_W{1'b0}};
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      inst_f_q     <= inst_f_d;
      read_data_q  <= read_data_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.inst_F       = inst_f_q;
  assign bus.read_data_M  = read_data_q;
  assign bus.inst_mem_ack = inst_ack_q;
  assign bus.data_mem_ack = data_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus transactions and responses are
// queued as stimulus is driven and checked when the DUT produces them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bus_t        exp_bus[$];
  logic [31:0] exp_inst[$];
  logic [31:0] exp_data[$];
  logic [31:0] inst_model;
  logic [31:0] rd_model;

  bus_t cur;
  logic cur_valid;
  int   bus_cnt;
  int   mem_lat;
  logic mem_stall;
  logic late_ack;
  logic saw_inst_ack;
  logic saw_data_ack;

  function automatic bus_t mk_bus(input logic [31:0] addr, input logic we,
                                  input logic [3:0] be, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
    bus_t b;
    b.addr  = addr;
    b.we    = we;
    b.be    = be;
    b.wdata = wdata;
    b.rdata = rdata;
    return b;
  endfunction

  // One clock: observe settled outputs at the falling edge, then play memory.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    saw_inst_ack = (ifc.inst_mem_ack === 1'b1);
    saw_data_ack = (ifc.data_mem_ack === 1'b1);
    if (saw_inst_ack) begin
      n_checks++;
      if (exp_inst.size() == 0) begin
        $display("FAIL inst_ack_unexpected: got inst_mem_ack=1 inst_F=%h, required no ack", ifc.inst_F);
      end else begin
        e = exp_inst.pop_front();
        if (ifc.inst_F !== e) $display("FAIL inst_F: got %h required %h", ifc.inst_F, e);
        else n_pass++;
      end
    end
    if (saw_data_ack) begin
      n_checks++;
      if (exp_data.size() == 0) begin
        $display("FAIL data_ack_unexpected: got data_mem_ack=1 read_data_M=%h, required no ack", ifc.read_data_M);
      end else begin
        e = exp_data.pop_front();
        if (ifc.read_data_M !== e) $display("FAIL read_data_M: got %h required %h", ifc.read_data_M, e);
        else n_pass++;
      end
    end
    ifc.mem_ack = 1'b0;
    if (ifc.mem_req === 1'b1) begin
      n_checks++;
      if (bus_cnt == 0) begin
        if (exp_bus.size() == 0) begin
          cur_valid = 1'b0;
          $display("FAIL bus_unexpected: got mem_req=1 addr=%h, required idle bus", ifc.mem_addr);
        end else begin
          cur = exp_bus.pop_front();
          cur_valid = 1'b1;
          if (ifc.mem_addr !== cur.addr || ifc.mem_we !== cur.we || ifc.mem_be !== cur.be ||
              (cur.we && ifc.mem_wdata !== cur.wdata))
            $display("FAIL bus_fields: got addr=%h we=%b be=%h wdata=%h required addr=%h we=%b be=%h wdata=%h",
                     ifc.mem_addr, ifc.mem_we, ifc.mem_be, ifc.mem_wdata,
                     cur.addr, cur.we, cur.be, cur.wdata);
          else n_pass++;
        end
      end else if (!cur_valid) begin
        $display("FAIL bus_stable: got mem_req=1 on unexpected transaction, required idle bus");
      end else if (ifc.mem_addr !== cur.addr || ifc.mem_we !== cur.we || ifc.mem_be !== cur.be ||
                   (cur.we && ifc.mem_wdata !== cur.wdata)) begin
        $display("FAIL bus_stable: got addr=%h we=%b be=%h required addr=%h we=%b be=%h",
                 ifc.mem_addr, ifc.mem_we, ifc.mem_be, cur.addr, cur.we, cur.be);
      end else begin
        n_pass++;
      end
      bus_cnt++;
      if (!mem_stall && bus_cnt == mem_lat) begin
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = cur.rdata;
      end
    end else begin
      bus_cnt   = 0;
      cur_valid = 1'b0;
    end
    if (late_ack) begin
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 32'h5A5A_5A5A;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ifc.mem_req !== 1'b0 || ifc.mem_we !== 1'b0 || ifc.mem_addr !== 32'h0 ||
        ifc.mem_wdata !== 32'h0 || ifc.mem_be !== 4'h0)
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h be=%h required all 0",
               ifc.mem_req, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.mem_be);
    else n_pass++;
    n_checks++;
    if (ifc.inst_mem_ack !== 1'b0 || ifc.data_mem_ack !== 1'b0)
      $display("FAIL reset_acks: got inst=%b data=%b required 0 0", ifc.inst_mem_ack, ifc.data_mem_ack);
    else n_pass++;
    n_checks++;
    if (ifc.inst_F !== 32'h0 || ifc.read_data_M !== 32'h0)
      $display("FAIL reset_data: got inst_F=%h read_data_M=%h required 0 0", ifc.inst_F, ifc.read_data_M);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE || dut.starve_cnt_q !== 3'd0 || dut.drop_q !== 1'b0)
      $display("FAIL reset_state: got state=%0d starve=%0d drop=%b required 0 0 0",
               dut.state_q, dut.starve_cnt_q, dut.drop_q);
    else n_pass++;
    reset = 1'b0;
    inst_model = 32'h0;
    rd_model   = 32'h0;
    tick();
  endtask

  task automatic test_fetch();
    int  lat;
    logic got;
    exp_bus.push_back(mk_bus(32'h0040_0004, 1'b0, 4'hF, 32'h0, 32'h2408_0001));
    exp_inst.push_back(32'h2408_0001);
    inst_model   = 32'h2408_0001;
    mem_lat      = 2;
    ifc.pc_F     = 32'h0040_0006;
    ifc.inst_req = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (saw_inst_ack) got = 1'b1;
    end
    ifc.inst_req = 1'b0;
    n_checks++;
    if (!got || lat != 3) $display("FAIL fetch_latency: got %0d cycles (ack=%b) required 3", lat, got);
    else n_pass++;
    tick();
    n_checks++;
    if (ifc.inst_mem_ack !== 1'b0 || ifc.inst_F !== inst_model)
      $display("FAIL fetch_pulse_hold: got ack=%b inst_F=%h required 0 %h", ifc.inst_mem_ack, ifc.inst_F, inst_model);
    else n_pass++;
    tick();
    n_checks++;
    if (ifc.mem_req !== 1'b0 || exp_bus.size() != 0 || exp_inst.size() != 0)
      $display("FAIL fetch_done: got mem_req=%b pending bus=%0d inst=%0d required 0 0 0",
               ifc.mem_req, exp_bus.size(), exp_inst.size());
    else n_pass++;
  endtask

  task automatic test_priority();
    int d_at;
    int i_at;
    exp_bus.push_back(mk_bus(32'h1000_0000, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h7777_7777));
    exp_bus.push_back(mk_bus(32'h0040_0008, 1'b0, 4'hF, 32'h0, 32'h8C09_0000));
    exp_data.push_back(rd_model);
    exp_inst.push_back(32'h8C09_0000);
    inst_model = 32'h8C09_0000;
    mem_lat = 1;
    ifc.data_req     = 1'b1;
    ifc.data_we      = 1'b1;
    ifc.alu_out_M    = 32'h1000_0002;
    ifc.write_data_M = 32'hDEAD_BEEF;
    ifc.byte_en_M    = 4'b0011;
    ifc.inst_req     = 1'b1;
    ifc.pc_F         = 32'h0040_0008;
    d_at = -1;
    i_at = -1;
    for (int i = 0; i < 30 && i_at < 0; i++) begin
      tick();
      if (saw_data_ack) begin ifc.data_req = 1'b0; d_at = i; end
      if (saw_inst_ack) begin ifc.inst_req = 1'b0; i_at = i; end
    end
    ifc.data_we = 1'b0;
    n_checks++;
    if (d_at < 0 || i_at < 0 || d_at >= i_at)
      $display("FAIL priority_order: got data_ack@%0d inst_ack@%0d required data first", d_at, i_at);
    else n_pass++;
    tick();
    n_checks++;
    if (ifc.read_data_M !== rd_model || exp_bus.size() != 0)
      $display("FAIL store_keeps_rdata: got read_data_M=%h pending bus=%0d required %h 0",
               ifc.read_data_M, exp_bus.size(), rd_model);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int   data_cnt;
    int   max_cnt;
    logic got;
    for (int k = 0; k < 4; k++) begin
      exp_bus.push_back(mk_bus(32'h2000_0000 + 32'(4 * k), 1'b0, 4'h0, 32'h0, 32'h1111_0000 + 32'(k)));
      exp_data.push_back(32'h1111_0000 + 32'(k));
    end
    exp_bus.push_back(mk_bus(32'h0040_0100, 1'b0, 4'hF, 32'h0, 32'h0000_0013));
    exp_inst.push_back(32'h0000_0013);
    inst_model = 32'h0000_0013;
    rd_model   = 32'h1111_0003;
    mem_lat = 1;
    ifc.byte_en_M = 4'h0;
    ifc.alu_out_M = 32'h2000_0000;
    ifc.pc_F      = 32'h0040_0100;
    ifc.data_req  = 1'b1;
    ifc.inst_req  = 1'b1;
    data_cnt = 0;
    max_cnt  = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (int'(dut.starve_cnt_q) > max_cnt) max_cnt = int'(dut.starve_cnt_q);
      if (saw_data_ack) begin
        data_cnt++;
        ifc.alu_out_M = 32'h2000_0000 + 32'(4 * data_cnt);
      end
      if (saw_inst_ack) begin
        got = 1'b1;
        ifc.inst_req = 1'b0;
        ifc.data_req = 1'b0;
      end
    end
    n_checks++;
    if (!got || data_cnt != 4)
      $display("FAIL starve_grants: got %0d data grants before inst (inst=%b) required 4", data_cnt, got);
    else n_pass++;
    n_checks++;
    if (max_cnt != 4) $display("FAIL starve_peak: got %0d required 4", max_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (dut.starve_cnt_q !== 3'd0 || ifc.read_data_M !== rd_model || exp_bus.size() != 0)
      $display("FAIL starve_after: got cnt=%0d read_data_M=%h pending=%0d required 0 %h 0",
               dut.starve_cnt_q, ifc.read_data_M, exp_bus.size(), rd_model);
    else n_pass++;
  endtask

  task automatic test_cancel();
    logic any_ack;
    logic got;
    int   lat_tab[2] = '{4, 2};
    int   at_tab[2]  = '{1, 2};
    for (int v = 0; v < 2; v++) begin
      exp_bus.push_back(mk_bus(32'h0040_0200, 1'b0, 4'hF, 32'h0, 32'hBAD0_BAD0));
      mem_lat = lat_tab[v];
      ifc.pc_F = 32'h0040_0202;
      ifc.inst_req = 1'b1;
      any_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        any_ack |= saw_inst_ack;
        ifc.inst_cancel = (i + 1 == at_tab[v]);
        if (i + 1 == at_tab[v]) ifc.inst_req = 1'b0;
      end
      ifc.inst_cancel = 1'b0;
      n_checks++;
      if (any_ack || ifc.inst_F !== inst_model || exp_bus.size() != 0 || dut.drop_q !== 1'b0)
        $display("FAIL cancel_%0d: got ack=%b inst_F=%h pending=%0d drop=%b required 0 %h 0 0",
                 v, any_ack, ifc.inst_F, exp_bus.size(), dut.drop_q, inst_model);
      else n_pass++;
    end
    exp_bus.push_back(mk_bus(32'h3000_0010, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001));
    exp_data.push_back(32'hCAFE_0001);
    rd_model = 32'hCAFE_0001;
    mem_lat = 2;
    ifc.alu_out_M = 32'h3000_0013;
    ifc.byte_en_M = 4'hF;
    ifc.data_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (saw_data_ack) begin got = 1'b1; ifc.data_req = 1'b0; end
    end
    n_checks++;
    if (!got) $display("FAIL after_cancel: got no data ack required ack");
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic any_ack;
    exp_bus.push_back(mk_bus(32'h4000_0000, 1'b0, 4'hF, 32'h0, 32'h0));
    mem_stall = 1'b1;
    ifc.alu_out_M = 32'h4000_0001;
    ifc.data_req  = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    ifc.data_req = 1'b0;
    tick();
    n_checks++;
    if (ifc.mem_req !== 1'b0 || ifc.inst_mem_ack !== 1'b0 || ifc.data_mem_ack !== 1'b0 ||
        ifc.read_data_M !== 32'h0 || dut.state_q !== IDLE)
      $display("FAIL reset_mid: got req=%b iack=%b dack=%b rdata=%h state=%0d required 0 0 0 0 0",
               ifc.mem_req, ifc.inst_mem_ack, ifc.data_mem_ack, ifc.read_data_M, dut.state_q);
    else n_pass++;
    reset     = 1'b0;
    mem_stall = 1'b0;
    rd_model   = 32'h0;
    inst_model = 32'h0;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    any_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_ack |= saw_inst_ack | saw_data_ack;
    end
    n_checks++;
    if (any_ack || ifc.read_data_M !== 32'h0 || ifc.mem_req !== 1'b0 || dut.state_q !== IDLE || exp_bus.size() != 0)
      $display("FAIL late_ack: got ack=%b rdata=%h req=%b state=%0d pending=%0d required 0 0 0 0 0",
               any_ack, ifc.read_data_M, ifc.mem_req, dut.state_q, exp_bus.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic req_trace[20];
    int   ack_at[2];
    int   n;
    exp_bus.push_back(mk_bus(32'h5000_0000, 1'b0, 4'hF, 32'h0, 32'h0101_0101));
    exp_bus.push_back(mk_bus(32'h5000_0004, 1'b0, 4'hF, 32'h0, 32'h0202_0202));
    exp_data.push_back(32'h0101_0101);
    exp_data.push_back(32'h0202_0202);
    rd_model = 32'h0202_0202;
    mem_lat = 1;
    ifc.alu_out_M = 32'h5000_0000;
    ifc.data_req  = 1'b1;
    n = 0;
    ack_at[0] = -1;
    ack_at[1] = -1;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick();
      req_trace[i] = ifc.mem_req;
      if (saw_data_ack) begin
        ack_at[n] = i;
        n++;
        ifc.alu_out_M = 32'h5000_0004;
        if (n == 2) ifc.data_req = 1'b0;
      end
    end
    n_checks++;
    if (n != 2 || ack_at[0] != 1 || ack_at[1] - ack_at[0] != 3)
      $display("FAIL turnaround: got acks=%0d at %0d,%0d required 2 at 1,4", n, ack_at[0], ack_at[1]);
    else n_pass++;
    n_checks++;
    if (n != 2 || req_trace[ack_at[0]] !== 1'b0 || req_trace[ack_at[1] - 1] !== 1'b1)
      $display("FAIL req_gap: got mem_req in RESP=%b required 0 between transactions",
               (n == 2) ? req_trace[ack_at[0]] : 1'bx);
    else n_pass++;
    tick();
    n_checks++;
    if (ifc.read_data_M !== rd_model || exp_bus.size() != 0 || exp_data.size() != 0)
      $display("FAIL b2b_done: got rdata=%h pending bus=%0d data=%0d required %h 0 0",
               ifc.read_data_M, exp_bus.size(), exp_data.size(), rd_model);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    ifc.inst_req     = 1'b0;
    ifc.inst_cancel  = 1'b0;
    ifc.pc_F         = 32'h0;
    ifc.data_req     = 1'b0;
    ifc.data_we      = 1'b0;
    ifc.alu_out_M    = 32'h0;
    ifc.write_data_M = 32'h0;
    ifc.byte_en_M    = 4'h0;
    ifc.mem_rdata    = 32'h0;
    ifc.mem_ack      = 1'b0;
    cur_valid  = 1'b0;
    bus_cnt    = 0;
    mem_lat    = 1;
    mem_stall  = 1'b0;
    late_ack   = 1'b0;
    inst_model = 32'h0;
    rd_model   = 32'h0;

    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_cancel();
    test_reset_mid();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
